// File: rtl/mips_muldiv_pkg.sv
// Shared control encodings for the HI/LO multiply/divide unit.
package mips_muldiv_pkg;

  // HI/LO unit operation codes; 6 and 7 are reserved and do nothing.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_e;

  // Sequencer states of the iterative engine.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // True for the two's-complement variants that need sign handling.
  function automatic logic f_op_is_signed(input op_e op);
    f_op_is_signed = (op == OP_MULT) || (op == OP_DIV);
  endfunction

  // True for the two division variants.
  function automatic logic f_op_is_div(input op_e op);
    f_op_is_div = (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mips_muldiv_unit_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
// Multiply: {hi,lo} holds {partial product, remaining multiplier bits}.
// Divide:   {hi,lo} holds {partial remainder, dividend bits / quotient bits}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // Compute the next accumulator value for the selected operation.
  always_comb begin
    w_sum   = {1'b0, i_hi} + {1'b0, i_operand};
    w_shift = {i_hi, i_lo[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, i_operand});
    // when w_ge holds the true difference is below the divisor, so it fits WIDTH bits
    w_diff  = w_shift[WIDTH-1:0] - i_operand;
    o_hi    = i_hi;
    o_lo    = i_lo;
    if (i_is_div) begin
      if (w_ge) begin
        o_hi = w_diff;
        o_lo = {i_lo[WIDTH-2:0], 1'b1};
      end else begin
        o_hi = w_shift[WIDTH-1:0];
        o_lo = {i_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (i_lo[0]) begin
        {o_hi, o_lo} = {w_sum, i_lo[WIDTH-1:1]};
      end else begin
        {o_hi, o_lo} = {1'b0, i_hi, i_lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS HI/LO unit: MULT/MULTU/DIV/DIVU in WIDTH+2 cycles, MTHI/MTLO in one.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             r_state;
  op_e                r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  op_e                w_op;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_is_div;
  logic               w_dbz;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_step_hi;
  logic [WIDTH-1:0]   w_step_lo;

  // Two's-complement magnitude of v when neg is set.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic neg);
    f_mag = neg ? (~v + WIDTH'(1)) : v;
  endfunction

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div  (w_is_div),
    .i_hi      (r_acc_hi),
    .i_lo      (r_acc_lo),
    .i_operand (r_opnd),
    .o_hi      (w_step_hi),
    .o_lo      (w_step_lo)
  );

  // Operand conditioning for the start cycle and sign correction for the FIX cycle.
  always_comb begin
    w_op       = op_e'(op);
    w_sa       = f_op_is_signed(w_op) & a[WIDTH-1];
    w_sb       = f_op_is_signed(w_op) & b[WIDTH-1];
    w_mag_a    = f_mag(a, w_sa);
    w_mag_b    = f_mag(b, w_sb);
    w_is_div   = f_op_is_div(r_op);
    w_dbz      = w_is_div && (r_opnd == {WIDTH{1'b0}});
    w_prod     = {r_acc_hi, r_acc_lo};
    w_prod_fix = r_neg_res ? (~w_prod + (2*WIDTH)'(1)) : w_prod;
    w_rem_fix  = r_neg_rem ? (~r_acc_hi + WIDTH'(1)) : r_acc_hi;
    // divide-by-zero leaves remainder = |a|, which sign-corrects back to a
    if (w_dbz) begin
      w_quo_fix = {WIDTH{1'b1}};
    end else begin
      w_quo_fix = r_neg_res ? (~r_acc_lo + WIDTH'(1)) : r_acc_lo;
    end
  end

  // Sequencer, datapath registers and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_MULT;
      r_cnt     <= {CNT_W{1'b0}};
      r_opnd    <= {WIDTH{1'b0}};
      r_acc_hi  <= {WIDTH{1'b0}};
      r_acc_lo  <= {WIDTH{1'b0}};
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
      r_hi      <= {WIDTH{1'b0}};
      r_lo      <= {WIDTH{1'b0}};
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cancel) begin
            r_state <= ST_IDLE;
          end else if (start) begin
            case (w_op)
              OP_MULT, OP_MULTU: begin
                r_state   <= ST_RUN;
                r_busy    <= 1'b1;
                r_op      <= w_op;
                r_cnt     <= {CNT_W{1'b0}};
                r_opnd    <= w_mag_a;
                r_acc_hi  <= {WIDTH{1'b0}};
                r_acc_lo  <= w_mag_b;
                r_neg_res <= w_sa ^ w_sb;
                r_neg_rem <= w_sa;
              end
              OP_DIV, OP_DIVU: begin
                r_state   <= ST_RUN;
                r_busy    <= 1'b1;
                r_op      <= w_op;
                r_cnt     <= {CNT_W{1'b0}};
                r_opnd    <= w_mag_b;
                r_acc_hi  <= {WIDTH{1'b0}};
                r_acc_lo  <= w_mag_a;
                r_neg_res <= w_sa ^ w_sb;
                r_neg_rem <= w_sa;
              end
              OP_MTHI: r_hi <= a;
              OP_MTLO: r_lo <= a;
              default: r_state <= ST_IDLE;
            endcase
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (cancel) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              r_state <= ST_FIX;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (!cancel) begin
            r_done <= 1'b1;
            r_dbz  <= w_dbz;
            if (w_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit: arithmetic reference model plus directed literal checks.
module tb_mips_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, cancel;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: remaining busy cycles and pending architectural result
  int           m_rem;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         m_done, m_dbz, p_dbz;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .div_by_zero(dbz),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // What HI/LO must become, from plain integer arithmetic.
  task automatic compute(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy, pu;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'd0, x};
    uy = {32'd0, y};
    p_dbz = 1'b0;
    case (o)
      3'd0: begin q = sx * sy; p_hi = q[63:32]; p_lo = q[31:0]; end
      3'd1: begin pu = ux * uy; p_hi = pu[63:32]; p_lo = pu[31:0]; end
      3'd2: begin
        if (y == 32'd0) begin p_dbz = 1'b1; p_hi = x; p_lo = 32'hFFFFFFFF; end
        else begin q = sx / sy; r = sx % sy; p_hi = r[31:0]; p_lo = q[31:0]; end
      end
      default: begin
        if (y == 32'd0) begin p_dbz = 1'b1; p_hi = x; p_lo = 32'hFFFFFFFF; end
        else begin pu = ux / uy; p_hi = 32'(ux % uy); p_lo = pu[31:0]; end
      end
    endcase
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_update();
    m_done = 1'b0;
    m_dbz  = 1'b0;
    if (reset) begin
      m_rem = 0; m_hi = '0; m_lo = '0;
    end else if (m_rem > 0) begin
      if (cancel) m_rem = 0;
      else begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dbz = p_dbz;
        end
      end
    end else if (start && !cancel) begin
      if (op <= 3'd3) begin
        compute(op, a, b);
        m_rem = W + 1;
      end else if (op == 3'd4) m_hi = a;
      else if (op == 3'd5) m_lo = a;
    end
  endtask

  task automatic compare();
    chk("busy", {63'd0, busy}, {63'd0, (m_rem > 0)});
    chk("done", {63'd0, done}, {63'd0, m_done});
    chk("div_by_zero", {63'd0, dbz}, {63'd0, m_dbz});
    chk("hi", {32'd0, hi}, {32'd0, m_hi});
    chk("lo", {32'd0, lo}, {32'd0, m_lo});
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
    compare();
  endtask

  // Launch one operation and follow it for a bounded number of cycles.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int dcyc, output int bcnt, output logic dz);
    start = 1'b1; op = o; a = x; b = y;
    dcyc = -1; bcnt = 0; dz = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1) start = 1'b0;
      if (busy) bcnt++;
      if (done && dcyc < 0) begin dcyc = k; dz = dbz; end
    end
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0: rnd_opnd = 32'd0;
      1: rnd_opnd = 32'h80000000;
      2: rnd_opnd = 32'hFFFFFFFF;
      3: rnd_opnd = 32'd1;
      4: rnd_opnd = 32'($urandom_range(0, 20));
      default: rnd_opnd = $urandom;
    endcase
  endfunction

  initial begin
    int   dc, bc;
    logic dz, saw;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0; a = '0; b = '0;
    step(); step();
    reset = 1'b0;
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);

    // signed multiply: -1 * 2
    run_op(3'd0, 32'hFFFFFFFF, 32'h00000002, dc, bc, dz);
    chk("mult_hi", {32'd0, hi}, 64'hFFFFFFFF);
    chk("mult_lo", {32'd0, lo}, 64'hFFFFFFFE);
    chk("mult_done_cycle", 64'(dc), 64'd34);
    chk("mult_busy_cycles", 64'(bc), 64'd33);

    run_op(3'd1, 32'hFFFFFFFF, 32'h00000002, dc, bc, dz);
    chk("multu_hi", {32'd0, hi}, 64'h00000001);
    chk("multu_lo", {32'd0, lo}, 64'hFFFFFFFE);

    run_op(3'd2, 32'hFFFFFFF9, 32'h00000002, dc, bc, dz);
    chk("div_lo", {32'd0, lo}, 64'hFFFFFFFD);
    chk("div_hi", {32'd0, hi}, 64'hFFFFFFFF);

    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, dc, bc, dz);
    chk("div_ovf_lo", {32'd0, lo}, 64'h80000000);
    chk("div_ovf_hi", {32'd0, hi}, 64'd0);
    chk("div_ovf_dbz", {63'd0, dz}, 64'd0);

    run_op(3'd3, 32'd5, 32'd0, dc, bc, dz);
    chk("divu0_lo", {32'd0, lo}, 64'hFFFFFFFF);
    chk("divu0_hi", {32'd0, hi}, 64'd5);
    chk("divu0_dbz", {63'd0, dz}, 64'd1);
    chk("divu0_done_cycle", 64'(dc), 64'd34);

    // MULT with an ignored MTLO while busy, then cancelled
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5; saw = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      step();
      if (done) saw = 1'b1;
      if (k == 11) chk("cancel_idle", {63'd0, busy}, 64'd0);
      if (k == 1) start = 1'b0;
      if (k == 5) begin start = 1'b1; op = 3'd5; a = 32'hDEAD; end
      if (k == 6) start = 1'b0;
      if (k == 10) cancel = 1'b1;
      if (k == 11) cancel = 1'b0;
    end
    chk("cancel_no_done", {63'd0, saw}, 64'd0);
    chk("cancel_hi", {32'd0, hi}, 64'd5);
    chk("cancel_lo", {32'd0, lo}, 64'hFFFFFFFF);

    // reset in the middle of a DIV, then MTHI
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7; saw = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) start = 1'b0;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    for (int k = 0; k < 20; k++) begin
      step();
      if (done) saw = 1'b1;
    end
    chk("rst_no_done", {63'd0, saw}, 64'd0);
    start = 1'b1; op = 3'd4; a = 32'h1234;
    step();
    start = 1'b0;
    chk("mthi_hi", {32'd0, hi}, 64'h1234);
    chk("mthi_busy", {63'd0, busy}, 64'd0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      start  = ($urandom_range(0, 3) == 0);
      op     = 3'($urandom_range(0, 7));
      a      = rnd_opnd();
      b      = rnd_opnd();
      cancel = ($urandom_range(0, 150) == 0);
      reset  = ($urandom_range(0, 700) == 0);
      step();
    end
    start = 1'b0; cancel = 1'b0; reset = 1'b0;
    for (int k = 0; k < 40; k++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
